// File: rtl/fpu_pkg.sv
// Single-precision constants, field view and classification helpers shared
// by the fadd output stage and its fixup logic.
package fpu_pkg;

  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP_NEG_INF = 32'hFF80_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  function automatic logic is_nan(fp32_t x);
    return (x.exp == FP_EXP_MAX) && (x.man != '0);
  endfunction

  function automatic logic is_inf(fp32_t x);
    return (x.exp == FP_EXP_MAX) && (x.man == '0);
  endfunction

endpackage

// File: rtl/fadd_fixup.sv
// Combinational IEEE-754 special-value fixup applied to the raw fadd result:
// NaN and Inf operands, then exponent overflow, in that priority.
module fadd_fixup
  import fpu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] res_i,
  input  logic        ovf_i,
  output logic [31:0] data_o,
  output logic        inv_o,
  output logic        ovf_o
);

  fp32_t a, b, res;

  assign a   = fp32_t'(a_i);
  assign b   = fp32_t'(b_i);
  assign res = fp32_t'(res_i);

  always_comb begin
    // NOTE: every output is defaulted before the priority chain so no branch can infer a latch.
    data_o = res_i;
    inv_o  = 1'b0;
    ovf_o  = 1'b0;
    if (is_nan(a) || is_nan(b)) begin
      data_o = FP_QNAN;
      inv_o  = 1'b1;
    end else if (is_inf(a) && is_inf(b) && (a.sign != b.sign)) begin
      data_o = FP_QNAN;
      inv_o  = 1'b1;
    end else if (is_inf(a)) begin
      data_o = {a.sign, FP_EXP_MAX, 23'h0};
    end else if (is_inf(b)) begin
      data_o = {b.sign, FP_EXP_MAX, 23'h0};
    end else if (ovf_i || (res.exp == FP_EXP_MAX)) begin
      data_o = {res.sign, FP_EXP_MAX, 23'h0};
      ovf_o  = 1'b1;
    end
  end

endmodule

// File: rtl/fadd_out_stage.sv
// Registered output stage for fadd: fixes up special values, buffers results
// in a 2-entry FIFO, keeps sticky exception flags and a completed-op counter.
module fadd_out_stage
  import fpu_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [31:0]      fadd_res,
  input  logic             fadd_ovf,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_inv,
  output logic             out_ovf,
  output logic             flag_inv,
  output logic             flag_ovf,
  input  logic             flag_clr,
  output logic [CNT_W-1:0] op_count
);

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             inv;
    logic             ovf;
  } entry_t;

  entry_t           mem_q [2];
  entry_t           head;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             flag_inv_q, flag_inv_d;
  logic             flag_ovf_q, flag_ovf_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             push, pop;
  logic [31:0]      fix_data;
  logic             fix_inv, fix_ovf;

  fadd_fixup u_fixup (
    .a_i    (in_a),
    .b_i    (in_b),
    .res_i  (fadd_res),
    .ovf_i  (fadd_ovf),
    .data_o (fix_data),
    .inv_o  (fix_inv),
    .ovf_o  (fix_ovf)
  );

  // in_ready looks only at the registered count, so out_ready never reaches it.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    flag_inv_d = flag_inv_q;
    flag_ovf_d = flag_ovf_q;
    op_count_d = op_count_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop) begin
      rd_ptr_d   = ~rd_ptr_q;
      op_count_d = op_count_q + CNT_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    // A flag being set in the same cycle as a clear takes precedence.
    if (flag_clr) begin
      flag_inv_d = 1'b0;
      flag_ovf_d = 1'b0;
    end
    if (push && fix_inv) flag_inv_d = 1'b1;
    if (push && fix_ovf) flag_ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      flag_inv_q <= 1'b0;
      flag_ovf_q <= 1'b0;
      op_count_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      flag_inv_q <= flag_inv_d;
      flag_ovf_q <= flag_ovf_d;
      op_count_q <= op_count_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; out_valid masks whatever it holds.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{data: fix_data, tag: in_tag, inv: fix_inv, ovf: fix_ovf};
  end

  assign head     = mem_q[rd_ptr_q];
  assign out_data = out_valid ? head.data : '0;
  assign out_tag  = out_valid ? head.tag  : '0;
  assign out_inv  = out_valid && head.inv;
  assign out_ovf  = out_valid && head.ovf;
  assign flag_inv = flag_inv_q;
  assign flag_ovf = flag_ovf_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_fadd_out_stage.sv
// Self-checking bench for fadd_out_stage: directed literal cases plus a long
// randomized run compared every cycle against a queue-based reference model.
module tb_fadd_out_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, fadd_ovf, out_valid, out_ready;
  logic [31:0] in_a, in_b, fadd_res, out_data;
  logic [3:0]  in_tag, out_tag;
  logic        out_inv, out_ovf, flag_inv, flag_ovf, flag_clr;
  logic [15:0] op_count;

  int n_checks = 0;
  int n_errs   = 0;
  bit check_en = 1'b0;

  fadd_out_stage #(.TAG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .fadd_res(fadd_res), .fadd_ovf(fadd_ovf),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_inv(out_inv), .out_ovf(out_ovf),
    .flag_inv(flag_inv), .flag_ovf(flag_ovf), .flag_clr(flag_clr), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        inv;
    logic        ovf;
  } exp_t;

  exp_t        m_q[$];
  logic        m_flag_inv = 1'b0, m_flag_ovf = 1'b0;
  logic [15:0] m_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference fixup written straight from the IEEE special-value rules.
  function automatic exp_t ref_fix(logic [31:0] a, logic [31:0] b, logic [31:0] r, logic o, logic [3:0] t);
    exp_t e;
    bit a_nan = ((a & 32'h7F80_0000) == 32'h7F80_0000) && ((a & 32'h007F_FFFF) != 0);
    bit b_nan = ((b & 32'h7F80_0000) == 32'h7F80_0000) && ((b & 32'h007F_FFFF) != 0);
    bit a_inf = (a & 32'h7FFF_FFFF) == 32'h7F80_0000;
    bit b_inf = (b & 32'h7FFF_FFFF) == 32'h7F80_0000;
    bit r_big = (r & 32'h7F80_0000) == 32'h7F80_0000;
    e.tag = t; e.inv = 1'b0; e.ovf = 1'b0; e.data = r;
    if (a_nan || b_nan || (a_inf && b_inf && ((a ^ b) >> 31) != 0)) begin
      e.data = 32'h7FC0_0000; e.inv = 1'b1;
    end else if (a_inf) e.data = a;
    else if (b_inf) e.data = b;
    else if (o || r_big) begin
      e.data = (r & 32'h8000_0000) | 32'h7F80_0000; e.ovf = 1'b1;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete(); m_flag_inv = 1'b0; m_flag_ovf = 1'b0; m_cnt = '0;
    end else begin
      automatic bit   do_pop  = (m_q.size() > 0) && out_ready;
      automatic bit   do_push = in_valid && (m_q.size() != 2);
      automatic exp_t e       = ref_fix(in_a, in_b, fadd_res, fadd_ovf, in_tag);
      if (flag_clr) begin m_flag_inv = 1'b0; m_flag_ovf = 1'b0; end
      if (do_push && e.inv) m_flag_inv = 1'b1;
      if (do_push && e.ovf) m_flag_ovf = 1'b1;
      if (do_pop) begin void'(m_q.pop_front()); m_cnt++; end
      if (do_push) m_q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("m_in_ready", in_ready, m_q.size() != 2);
      check("m_out_valid", out_valid, m_q.size() > 0);
      if (m_q.size() > 0) begin
        check("m_out_data", out_data, m_q[0].data);
        check("m_out_tag", out_tag, m_q[0].tag);
        check("m_out_inv", out_inv, m_q[0].inv);
        check("m_out_ovf", out_ovf, m_q[0].ovf);
      end
      check("m_flag_inv", flag_inv, m_flag_inv);
      check("m_flag_ovf", flag_ovf, m_flag_ovf);
      check("m_op_count", op_count, m_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic o, input logic [3:0] t);
    in_valid = v; in_a = a; in_b = b; fadd_res = r; fadd_ovf = o; in_tag = t;
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] r = $urandom();
    case ($urandom_range(0, 7))
      0: return 32'h7F80_0000;
      1: return 32'hFF80_0000;
      2: return {r[31], 8'hFF, r[22:1], 1'b1};
      3: return {r[31], 8'hFE, r[22:0]};
      default: return r;
    endcase
  endfunction

  initial begin
    rst = 1'b1; out_ready = 1'b0; flag_clr = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 4'h0);
    step();
    check_en = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_flags", {flag_inv, flag_ovf, out_inv, out_ovf}, 0);
    check("rst_op_count", op_count, 0);
    rst = 1'b0;

    // 1.0 + 2.0 = 3.0 passes through unchanged
    out_ready = 1'b1;
    drive(1'b1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 4'h5);
    step();
    check("add_data", out_data, 32'h4040_0000);
    check("add_tag", out_tag, 4'h5);
    check("add_exc", {out_inv, out_ovf}, 0);
    drive(1'b0, '0, '0, '0, 1'b0, 4'h0);
    step();
    check("add_popped", op_count, 1);

    // +Inf + -Inf is invalid
    drive(1'b1, 32'h7F80_0000, 32'hFF80_0000, 32'h0, 1'b0, 4'h1);
    step();
    check("inf_data", out_data, 32'h7FC0_0000);
    check("inf_inv", {out_inv, flag_inv}, 2'b11);
    drive(1'b0, '0, '0, '0, 1'b0, 4'h0);
    step();

    // max finite + max finite overflows to +Inf
    drive(1'b1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b0, 4'h2);
    step();
    check("ovf_data", out_data, 32'h7F80_0000);
    check("ovf_flag", {out_ovf, flag_ovf, out_inv}, 3'b110);
    drive(1'b0, '0, '0, '0, 1'b0, 4'h0);
    flag_clr = 1'b1;
    step();
    check("clr_flags", {flag_inv, flag_ovf}, 0);
    flag_clr = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Backpressure: third push stalls until the full FIFO drains
    out_ready = 1'b0;
    drive(1'b1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 4'h0);
    step();
    check("bp_ready1", in_ready, 1);
    in_tag = 4'h1;
    step();
    check("bp_full", in_ready, 0);
    in_tag = 4'h2;
    step();
    check("bp_head0", out_tag, 4'h0);
    out_ready = 1'b1;
    step();
    check("bp_head1", out_tag, 4'h1);
    step();
    check("bp_head2", out_tag, 4'h2);
    in_valid = 1'b0;
    step();
    check("bp_empty", out_valid, 0);
    check("bp_count", op_count, 3);

    // Reset with two buffered invalid entries discards them
    out_ready = 1'b0;
    drive(1'b1, 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0001, 1'b0, 4'h7);
    step();
    step();
    drive(1'b0, '0, '0, '0, 1'b0, 4'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rr_valid", out_valid, 0);
    check("rr_flags", {flag_inv, flag_ovf}, 0);
    check("rr_count", op_count, 0);
    check("rr_ready", in_ready, 1);

    // Set wins over a simultaneous clear
    out_ready = 1'b1; flag_clr = 1'b1;
    drive(1'b1, 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0001, 1'b0, 4'h3);
    step();
    check("setwin_flag", flag_inv, 1);
    check("setwin_data", out_data, 32'h7FC0_0000);
    in_valid = 1'b0;
    step();
    check("clr_after", flag_inv, 0);
    flag_clr = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      flag_clr  = ($urandom_range(0, 15) == 0);
      drive($urandom_range(0, 9) < 7, rand_op(), rand_op(), $urandom(),
            $urandom_range(0, 7) == 0, 4'($urandom()));
      if ($urandom_range(0, 3) == 0) fadd_res[30:23] = 8'hFF;
      step();
    end

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
